// File: rtl/cfg_counter_if.sv
// Control and status bundle for cfg_counter: the controller drives the strobes and
// compare/load values, and the counter returns its registered state.
interface cfg_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] match_val;
    logic             clear_hit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             hit;
    logic             stopped;

    modport master (
        output en, up, load, load_val, match_val, clear_hit,
        input  count, tc, hit, stopped
    );

    modport slave (
        input  en, up, load, load_val, match_val, clear_hit,
        output count, tc, hit, stopped
    );
endinterface

// File: rtl/cfg_counter.sv
// Configurable up/down event counter with wrap or saturate boundaries, a registered
// terminal-count pulse, and a sticky match detector that can freeze the count.
module cfg_counter #(
    parameter int WIDTH         = 4,
    parameter int MAX_VAL       = 15,
    parameter int SATURATE      = 0,
    parameter int STOP_ON_MATCH = 1
) (
    input  logic          clk,
    input  logic          reset,
    cfg_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             hit_q, hit_d;
    logic             stopped_q, stopped_d;
    logic             update;
    logic             match;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that leaves one unassigned infers a latch.
        count_d = count_q;
        tc_d    = 1'b0;
        update  = 1'b0;

        if (bus.load) begin
            count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
            update  = 1'b1;
        end else if (bus.en && !stopped_q) begin
            update = 1'b1;
            if (bus.up) begin
                if (count_q == MAX_C) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? MAX_C : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? '0 : MAX_C;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // A match is an event on update, so a saturate hold or same-value load still fires.
        match     = update && (count_d == bus.match_val);
        hit_d     = match || (hit_q && !bus.clear_hit);
        stopped_d = (STOP_ON_MATCH != 0)
                    && (match || (stopped_q && !bus.clear_hit && !bus.load));
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            hit_q     <= 1'b0;
            stopped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            hit_q     <= hit_d;
            stopped_q <= stopped_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.hit     = hit_q;
    assign bus.stopped = stopped_q;
endmodule

// File: doc/cfg_counter.md
Name: cfg_counter

Overview:
- Parametrised successor to the team's fixed 4-bit free-running counter.
- Adds:
  - configurable width and modulus
  - up/down direction, enable and synchronous parallel load
  - wrap or saturate mode, selected by parameter
  - registered terminal-count pulse
  - programmable match detector with sticky hit flag and optional stop-on-match freeze
- Used as event/timeout counter in FV test designs; its outputs are intended as assertion targets (e.g. "count stable after reaching match").

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MAX_VAL, 15, terminal value; count range is 0..MAX_VAL; must be <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.
- STOP_ON_MATCH, 1, 1 = counter freezes when a match event occurs until clear_hit or load.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  load value.
- match_val  input  WIDTH  compare value; sampled every cycle.
- clear_hit  input  1  clears hit and stopped.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, 1 cycle).
- hit  output  1  sticky match flag (registered).
- stopped  output  1  counter frozen by match (registered; always 0 when STOP_ON_MATCH=0).

Behaviour:
- Reset (synchronous): count=0, tc=0, hit=0, stopped=0. Reset overrides all other inputs and suppresses match detection, even when match_val=0.
- Priority, highest first: reset > load > count step.
- Load:
  - next count = load_val clamped to MAX_VAL (load_val > MAX_VAL loads MAX_VAL).
  - Clears stopped.
  - Ignores en and stopped.
  - tc=0 for a load cycle.
- Step condition: en && !stopped && !load.
  - Up, count < MAX_VAL: count+1.
  - Up, count == MAX_VAL: wrap to 0 (SATURATE=0) or hold at MAX_VAL (SATURATE=1).
  - Down, count > 0: count-1.
  - Down, count == 0: wrap to MAX_VAL (SATURATE=0) or hold at 0 (SATURATE=1).
  - No step: count holds.
- tc:
  - Asserted for exactly the cycle after a step taken at a boundary (up at MAX_VAL or down at 0), in both modes.
  - In saturate mode, repeated enabled steps at the boundary give tc high continuously.
  - tc=0 otherwise.
- Match event:
  - Fires when a step or load produces next count == match_val, including next == current (a saturate hold or a load of the same value).
  - On the event, hit<=1 and (STOP_ON_MATCH=1) stopped<=1, both in the same edge that updates count. The first cycle with count==match_val therefore also shows hit=1 and stopped=1.
  - A match is an event on update, not a level compare: a stationary count equal to a newly changed match_val does not fire.
- While stopped: count, tc frozen (tc forced 0); en is ignored.
- clear_hit:
  - Next cycle hit=0 and stopped=0.
  - If a match event occurs in the same cycle, set wins (hit and stopped stay 1).
  - Stepping resumes the cycle after clear; leaving match_val does not re-fire.
- Load and clear_hit together: load applied, clear applied; a match on the loaded value then sets hit/stopped (set wins).
- Reset mid-stop or mid-count: all state returns to reset values next edge; no tc or hit pulse is generated by reset.
- Out-of-range match_val (> MAX_VAL): never matches under stepping; a clamped load cannot match either.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0, STOP=0, en=1, up=1 from reset -> count 0..9,0,1; tc=1 only in the cycle count shows 0 after 9; hit stays 0 (match_val=12).
- SATURATE=1, down, start 2 -> count 1,0,0,0; tc=0,0,1,1 in those cycles; count never wraps to 9.
- STOP=1, match_val=10, MAX_VAL=15, up from 0 -> count reaches 10 with hit=1 and stopped=1 that same cycle; count stays 10 for 5 cycles with en=1; pulse clear_hit -> next cycles 10,11,12 and hit=0, no re-fire.
- load=1, load_val=14, MAX_VAL=9 -> count=9 next cycle; with match_val=9 -> hit=1, stopped=1 same cycle.
- clear_hit asserted in the cycle a step enters match_val=5 -> hit and stopped remain 1.
- Reset asserted while stopped=1, count=10 -> next edge count=0, hit=0, stopped=0, tc=0; with match_val=0, hit stays 0 during reset.
